// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic register slice that moves one control field and one payload from
//   one pipeline stage to the next. A flush turns the stage into a bubble
//   whose control bits are all zero. The stored data is left as it was.
//
//   Optional feature macro: PIPE_STAGE_SKID_EN
//     defined   : adds a skid entry (S) behind the main entry (M). in_ready
//                 becomes a pure register output and occupancy runs 0..2.
//     undefined : M only. in_ready = !M.valid | out_ready (combinational).
//                 occupancy runs 0..1.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-high; empties the stage immediately
//     flush      synchronous; drops held entries and the incoming entry
//     in_valid   upstream presents an entry
//     in_ready   stage accepts an entry this cycle
//     in_ctrl    upstream control bits  [CTRL_W]
//     in_data    upstream payload       [DATA_W]
//     out_valid  stage presents the head entry (M)
//     out_ready  downstream accepts; low means stall
//     out_ctrl   head control bits, zero whenever out_valid is low
//     out_data   head payload
//     occupancy  number of entries held
//
//   Handshake: an entry moves on an edge when valid and ready are both high
//   on the same side. A producer must hold valid and its payload stable until
//   that edge. Neither side makes valid depend on ready.

module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;

    logic accept;
    logic issue;

    assign issue  = m_valid_q & out_ready;
    assign accept = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    // S is only written while it is empty. This keeps in_ready a flop output,
    // and upstream learns about a stall one cycle late without losing data.
    assign in_ready  = ~s_valid_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (!m_valid_q || issue) begin
            if (s_valid_q) begin
                // The older entry in S moves up first, so FIFO order is kept.
                m_valid_d = 1'b1;
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = accept;
                if (accept) begin
                    s_ctrl_d = in_ctrl;
                    s_data_d = in_data;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
                end
            end
        end else if (accept) begin
            // M is holding, so the new entry parks in S.
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end
`else
    // No skid: M can take a new entry in the same cycle that it issues.
    assign in_ready  = ~m_valid_q | out_ready;
    assign occupancy = {1'b0, m_valid_q};

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
        end else if (!m_valid_q || issue) begin
            m_valid_d = accept;
            if (accept) begin
                m_ctrl_d = in_ctrl;
                m_data_d = in_data;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
        end
    end

    assign out_valid = m_valid_q;
    // Gate the control bits so that a bubble cannot write registers or memory.
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;

endmodule
